// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_muldiv_seq: 32-bit unsigned MUL/DIVU/REMU sequenced through the shared ALU
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_ctrl,
  output logic              alu_src,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DCMP = 3'd2;
  localparam logic [2:0] S_DSUB = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_SLT = 3'b101;

  localparam logic [4:0] LAST_ITER = 5'd31;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [1:0]        op;
  // acc doubles as the remainder, opa as multiplicand/quotient, opb as multiplier/divisor
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [4:0]        cnt;
  logic              lt;
  logic [DATA_W-1:0] rem_sh;
  logic              accept;
  logic              div_by_zero;

  assign rem_sh      = {acc[DATA_W-2:0], opa[DATA_W-1]};
  assign accept      = (state == S_IDLE) && req_valid;
  assign div_by_zero = (req_op != OP_MUL) && (req_op != OP_ILL) && (req_b == '0);
  assign alu_src     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_ILL || div_by_zero) state_nxt = S_DONE;
          else if (req_op == OP_MUL)           state_nxt = S_MUL;
          else                                 state_nxt = S_DCMP;
        end
      end
      S_MUL:  if (alu_gnt && cnt == LAST_ITER) state_nxt = S_DONE;
      S_DCMP: if (alu_gnt) state_nxt = S_DSUB;
      S_DSUB: if (alu_gnt) state_nxt = (cnt == LAST_ITER) ? S_DONE : S_DCMP;
      S_DONE: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_DONE);
    alu_req    = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_ctrl   = CTRL_ADD;
    case (state)
      S_MUL: begin
        alu_req  = 1'b1;
        alu_op1  = acc;
        alu_op2  = opb[0] ? opa : '0;
        alu_ctrl = CTRL_ADD;
      end
      S_DCMP: begin
        alu_req  = 1'b1;
        alu_op1  = rem_sh;
        alu_op2  = opb;
        alu_ctrl = CTRL_SLT;
      end
      S_DSUB: begin
        alu_req  = 1'b1;
        alu_op1  = acc;
        alu_op2  = opb;
        alu_ctrl = CTRL_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      cnt       <= '0;
      lt        <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op       <= req_op;
            opa      <= req_a;
            opb      <= req_b;
            acc      <= '0;
            cnt      <= '0;
            lt       <= 1'b0;
            resp_err <= (req_op == OP_ILL);
            if (req_op == OP_ILL)  resp_data <= '0;
            else if (div_by_zero)  resp_data <= (req_op == OP_DIVU) ? '1 : req_a;
          end
        end
        S_MUL: begin
          if (alu_gnt) begin
            acc <= alu_result;
            opa <= {opa[DATA_W-2:0], 1'b0};
            opb <= {1'b0, opb[DATA_W-1:1]};
            cnt <= cnt + 5'd1;
            if (cnt == LAST_ITER) resp_data <= alu_result;
          end
        end
        S_DCMP: begin
          if (alu_gnt) begin
            acc <= rem_sh;
            opa <= {opa[DATA_W-2:0], 1'b0};
            // A carried-out bit means rem_sh exceeds any 32-bit divisor: force the subtract
            lt  <= acc[DATA_W-1] ? 1'b0 : alu_result[0];
          end
        end
        S_DSUB: begin
          if (alu_gnt) begin
            if (!lt) begin
              acc    <= alu_result;
              opa[0] <= 1'b1;
            end
            cnt <= cnt + 5'd1;
            if (cnt == LAST_ITER) begin
              if (op == OP_DIVU) resp_data <= {opa[DATA_W-1:1], opa[0] | ~lt};
              else               resp_data <= lt ? acc : alu_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_muldiv_seq: directed scoreboard bench for alu_muldiv_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] alu_result;

  alu_muldiv_seq #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // Shared single-cycle ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000:  alu_result = alu_op1 + alu_op2;
      3'b001:  alu_result = alu_op1 - alu_op2;
      3'b101:  alu_result = {31'd0, (alu_op1 < alu_op2)};
      default: alu_result = '0;
    endcase
  end

  int   tick = 0;
  logic tog = 1'b0;
  logic gnt_toggle = 1'b0;
  always @(posedge clk) tick <= tick + 1;
  always @(posedge clk) tog <= ~tog;
  assign alu_gnt = gnt_toggle ? tog : 1'b1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          issue_tick;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic [1:0] cur_op = 2'b00;
  logic       cur_noalu = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake
  logic        prev_valid = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_frozen = 1'b0;
  logic [31:0] sv_op1, sv_op2;
  logic [2:0]  sv_ctrl;
  logic [2:0]  exp_dctrl = 3'b101;
  int          wd = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_alu_op1", alu_op1, 32'd0);
      prev_valid  = 1'b0;
      prev_req    = 1'b0;
      prev_frozen = 1'b0;
    end else begin
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
        end else if (sb[0].lat >= 0) begin
          chk("latency", tick - sb[0].issue_tick, sb[0].lat);
        end
      end
      if (resp_valid && !resp_ready && sb.size() > 0) begin
        chk("stall_data", resp_data, sb[0].data);
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (resp_valid && resp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
      if (sb.size() > 0 && !resp_valid) wd++;
      else wd = 0;
      if (wd > 200) begin
        chk("resp_timeout", 32'd0, 32'd1);
        void'(sb.pop_front());
        wd = 0;
      end
      if (cur_noalu) chk("no_alu_req", {31'd0, alu_req}, 32'd0);
      if (!alu_req) begin
        chk("idle_alu_bus", {alu_op1 | alu_op2, 29'd0, alu_ctrl}, 64'd0);
      end else if (cur_op == 2'b00) begin
        chk("mul_ctrl", {29'd0, alu_ctrl}, 32'd0);
      end else begin
        if (!prev_req) exp_dctrl = 3'b101;
        chk("div_ctrl", {29'd0, alu_ctrl}, {29'd0, exp_dctrl});
        if (alu_gnt) exp_dctrl = (exp_dctrl == 3'b101) ? 3'b001 : 3'b101;
      end
      if (prev_frozen && alu_req) begin
        chk("frozen_op1", alu_op1, sv_op1);
        chk("frozen_op2", alu_op2, sv_op2);
        chk("frozen_ctrl", {29'd0, alu_ctrl}, {29'd0, sv_ctrl});
      end
      prev_frozen = alu_req && !alu_gnt;
      sv_op1      = alu_op1;
      sv_op2      = alu_op2;
      sv_ctrl     = alu_ctrl;
      prev_valid  = resp_valid;
      prev_req    = alu_req;
    end
  end

  // lat = -2 derives the latency of a toggled-grant MUL from the grant phase
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic exp_err, input int lat,
                       input bit push);
    int   w = 0;
    exp_t e;
    while (!req_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    cur_op    = op;
    cur_noalu = (op == 2'b11) || (op != 2'b00 && b == 32'd0);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    e.data       = exp_data;
    e.err        = exp_err;
    e.issue_tick = tick;
    e.lat        = (lat == -2) ? (tog ? 65 : 64) : lat;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || !req_ready) && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  initial begin
    int w;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0, 33, 1'b1);
    wait_idle();
    gnt_toggle = 1'b1;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, -2, 1'b1);
    wait_idle();
    gnt_toggle = 1'b0;
    issue(2'b00, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 33, 1'b1);
    issue(2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 33, 1'b1);
    issue(2'b01, 32'd100, 32'd7, 32'h0000000E, 1'b0, 65, 1'b1);
    issue(2'b10, 32'd100, 32'd7, 32'h00000002, 1'b0, 65, 1'b1);
    issue(2'b01, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0, 65, 1'b1);
    issue(2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 65, 1'b1);
    issue(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 1'b1);
    issue(2'b10, 32'h00001234, 32'd0, 32'h00001234, 1'b0, 1, 1'b1);
    issue(2'b11, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1, 1'b1);
    wait_idle();

    resp_ready = 1'b0;
    issue(2'b01, 32'd1000, 32'd10, 32'd100, 1'b0, 65, 1'b1);
    w = 0;
    while (!resp_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (10) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle();

    issue(2'b01, 32'd1000, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    issue(2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 33, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
